// File: rtl/flash_wr_seq.sv
// flash_wr_seq: sequences CPU writes into flash WE_n pulses and DTACK_n.
// Optional busy timeout: `define FLASH_WR_TIMEOUT_EN.
module flash_wr_seq #(
   parameter int WE_SETUP = 1,
   parameter int WE_PULSE = 2,
   parameter int WE_HOLD  = 1,
   parameter int BUSY_DLY = 2,
   parameter int TIMEOUT  = 20000
) (
   input  logic CLKCPU,
   input  logic RESET_n,
   input  logic AS_CPU_n,
   input  logic DS_n,
   input  logic RW_n,
   input  logic FLASH_ACCESS,
   input  logic WRITE_EN,
   input  logic FLASH_BUSY_n,
   output logic FLASH_WE_n,
   output logic DTACK_n,
   output logic WR_ACTIVE,
   output logic WR_ERR
);

   typedef enum logic [2:0] {
      IDLE, SETUP, PULSE, HOLD, BUSY_WAIT, ACK
   } state_t;

   localparam logic [2:0] SETUP_LAST = 3'(WE_SETUP - 1);
   localparam logic [2:0] PULSE_LAST = 3'(WE_PULSE - 1);
   localparam logic [2:0] HOLD_LAST  = 3'(WE_HOLD - 1);
   localparam logic [2:0] BUSY_IGN   = 3'(BUSY_DLY);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       abort, abort_nxt, abort_now;
   logic       busy_s1, busy_s2;
   logic       req, busy_rdy, tmo_hit;

   assign req = !AS_CPU_n && !DS_n && !RW_n && FLASH_ACCESS;
   assign busy_rdy = (cnt >= BUSY_IGN) && busy_s2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 3'd1;
      abort_nxt = abort;
      abort_now = abort | AS_CPU_n;
      unique case (state)
         IDLE: begin
            cnt_nxt   = '0;
            abort_nxt = 1'b0;
            if (req) state_nxt = WRITE_EN ? SETUP : ACK;
         end
         SETUP: begin
            if (AS_CPU_n) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == SETUP_LAST) begin
               state_nxt = PULSE;
               cnt_nxt   = '0;
            end
         end
         // an abort here is deferred so the pulse is never cut short
         PULSE: begin
            abort_nxt = abort_now;
            if (cnt == PULSE_LAST) begin
               cnt_nxt = '0;
               if (WE_HOLD != 0) state_nxt = HOLD;
               else state_nxt = abort_now ? IDLE : BUSY_WAIT;
            end
         end
         HOLD: begin
            abort_nxt = abort_now;
            if (cnt == HOLD_LAST) begin
               cnt_nxt   = '0;
               state_nxt = abort_now ? IDLE : BUSY_WAIT;
            end
         end
         BUSY_WAIT: begin
            cnt_nxt = (cnt < BUSY_IGN) ? cnt + 3'd1 : cnt;
            if (AS_CPU_n) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (busy_rdy || tmo_hit) begin
               state_nxt = ACK;
               cnt_nxt   = '0;
            end
         end
         ACK: begin
            cnt_nxt = '0;
            if (AS_CPU_n) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLKCPU) begin
      if (!RESET_n) begin
         state      <= IDLE;
         cnt        <= '0;
         abort      <= 1'b0;
         busy_s1    <= 1'b1;
         busy_s2    <= 1'b1;
         FLASH_WE_n <= 1'b1;
         DTACK_n    <= 1'b1;
         WR_ACTIVE  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         abort      <= abort_nxt;
         busy_s1    <= FLASH_BUSY_n;
         busy_s2    <= busy_s1;
         FLASH_WE_n <= state_nxt != PULSE;
         DTACK_n    <= state_nxt != ACK;
         WR_ACTIVE  <= state_nxt != IDLE;
      end
   end

`ifdef FLASH_WR_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign tmo_hit = tmo_cnt == 16'(TIMEOUT - 1);

   always_ff @(posedge CLKCPU) begin
      if (!RESET_n) begin
         tmo_cnt <= '0;
         WR_ERR  <= 1'b0;
      end else begin
         tmo_cnt <= (state == BUSY_WAIT) ? tmo_cnt + 16'd1 : '0;
         if (state == BUSY_WAIT && state_nxt == ACK && !busy_rdy)
            WR_ERR <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign WR_ERR  = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_flash_wr_seq.sv
// tb_flash_wr_seq: directed bench for flash_wr_seq with a timeline model.
// Timeout cases build only with FLASH_WR_TIMEOUT_EN defined.
module tb_flash_wr_seq;

   localparam int SU  = 1;
   localparam int PW  = 2;
   localparam int HD  = 1;
   localparam int BD  = 2;
   localparam int TMO = 20000;
   localparam int TBW = SU + PW + HD;

   logic CLKCPU = 1'b0;
   logic RESET_n = 1'b0;
   logic AS_CPU_n = 1'b1;
   logic DS_n = 1'b1;
   logic RW_n = 1'b1;
   logic FLASH_ACCESS = 1'b0;
   logic WRITE_EN = 1'b1;
   logic FLASH_BUSY_n = 1'b1;
   logic FLASH_WE_n, DTACK_n, WR_ACTIVE, WR_ERR;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 CLKCPU = ~CLKCPU;

   flash_wr_seq dut (
      .CLKCPU(CLKCPU),
      .RESET_n(RESET_n),
      .AS_CPU_n(AS_CPU_n),
      .DS_n(DS_n),
      .RW_n(RW_n),
      .FLASH_ACCESS(FLASH_ACCESS),
      .WRITE_EN(WRITE_EN),
      .FLASH_BUSY_n(FLASH_BUSY_n),
      .FLASH_WE_n(FLASH_WE_n),
      .DTACK_n(DTACK_n),
      .WR_ACTIVE(WR_ACTIVE),
      .WR_ERR(WR_ERR)
   );

   task automatic chk(input string nm, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Timeline model: outputs derived from cycles elapsed since capture.
   bit started = 0;
   bit m_act, m_ack, m_ab, m_err;
   int m_t;
   bit h1 = 1, h2 = 1;
   bit e_we = 1, e_dt = 1, e_act = 0, e_err = 0;

   always @(posedge CLKCPU) begin
      bit sync, as_hi;
      int j;
      cyc++;
      sync  = h2;
      h2    = h1;
      h1    = FLASH_BUSY_n;
      as_hi = AS_CPU_n;
      if (!RESET_n) begin
         m_act = 0; m_ack = 0; m_ab = 0; m_err = 0; m_t = 0;
         h1 = 1; h2 = 1; started = 1;
      end else if (!m_act) begin
         if (!AS_CPU_n && !DS_n && !RW_n && FLASH_ACCESS) begin
            m_act = 1; m_t = 0; m_ab = 0; m_ack = !WRITE_EN;
         end
      end else if (m_ack) begin
         if (as_hi) m_act = 0;
      end else begin
         j = m_t;
         m_t++;
         if (j < SU) begin
            if (as_hi) m_act = 0;
         end else if (j < TBW) begin
            if (as_hi) m_ab = 1;
            if (j == TBW - 1 && m_ab) m_act = 0;
         end else begin
            if (as_hi) m_act = 0;
            else if (j - TBW >= BD && sync) m_ack = 1;
`ifdef FLASH_WR_TIMEOUT_EN
            else if (j - TBW + 1 == TMO) begin
               m_ack = 1; m_err = 1;
            end
`endif
         end
      end
      e_act = m_act;
      e_dt  = !(m_act && m_ack);
      e_we  = !(m_act && !m_ack && m_t >= SU && m_t < SU + PW);
      e_err = m_err;
   end

   always @(negedge CLKCPU) begin
      if (started) begin
         chk("we_n", FLASH_WE_n, e_we);
         chk("dtack_n", DTACK_n, e_dt);
         chk("wr_active", WR_ACTIVE, e_act);
         chk("wr_err", WR_ERR, e_err);
      end
   end

   task automatic start_wr(input logic wen);
      @(negedge CLKCPU);
      AS_CPU_n = 0; DS_n = 0; RW_n = 0;
      FLASH_ACCESS = 1; WRITE_EN = wen;
   endtask

   task automatic idle_bus();
      AS_CPU_n = 1; DS_n = 1; RW_n = 1;
      FLASH_ACCESS = 0; FLASH_BUSY_n = 1;
      @(negedge CLKCPU);
   endtask

   // k = 0 is the negedge right after the capture edge
   task automatic watch(input int n, input int as_up,
                        input int blo, input int bhi,
                        output int we_cnt, output int we_first,
                        output int dt_first, output int dt_last,
                        output int idle_k, output int act_cnt);
      we_cnt = 0; we_first = -1; dt_first = -1;
      dt_last = -1; idle_k = -1; act_cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge CLKCPU);
         if (FLASH_WE_n === 1'b0) begin
            we_cnt++;
            if (we_first < 0) we_first = k;
         end
         if (DTACK_n === 1'b0) begin
            if (dt_first < 0) dt_first = k;
            dt_last = k;
         end
         if (WR_ACTIVE === 1'b1) act_cnt++;
         else if (idle_k < 0) idle_k = k;
         FLASH_BUSY_n = !(k >= blo && k < bhi);
         if (k == as_up) begin
            AS_CPU_n = 1; DS_n = 1;
         end
      end
      AS_CPU_n = 1; DS_n = 1; FLASH_BUSY_n = 1;
   endtask

   initial begin
      int wc, wf, df, dl, ik, ac;
      repeat (3) @(negedge CLKCPU);
      chk("rst_we", FLASH_WE_n, 1'b1);
      chk("rst_dt", DTACK_n, 1'b1);
      chk("rst_act", WR_ACTIVE, 1'b0);
      chk("rst_err", WR_ERR, 1'b0);
      RESET_n = 1;
      idle_bus();

      start_wr(1);
      watch(12, 9, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("wr_we_first", wf, 1);
      chk_i("wr_we_cnt", wc, 2);
      chk_i("wr_dt_first", df, 7);
      chk_i("wr_dt_last", dl, 9);
      chk_i("wr_idle", ik, 10);

      start_wr(1);
      watch(12, 8, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("b2b_dt_first", df, 7);
      idle_bus();

      start_wr(0);
      watch(6, 3, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("dis_we_cnt", wc, 0);
      chk_i("dis_dt_first", df, 0);
      chk_i("dis_dt_last", dl, 3);
      idle_bus();

      start_wr(1);
      watch(112, 108, 3, 103, wc, wf, df, dl, ik, ac);
      chk_i("busy_we_cnt", wc, 2);
      chk_i("busy_dt_first", df, 106);
      chk_i("busy_idle", ik, 109);
      chk("busy_err", WR_ERR, 1'b0);
      idle_bus();

      start_wr(1);
      watch(8, 1, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("abp_we_cnt", wc, 2);
      chk_i("abp_dt", df, -1);
      chk_i("abp_idle", ik, 4);
      idle_bus();

      start_wr(1);
      watch(4, 0, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("abs_we_cnt", wc, 0);
      chk_i("abs_idle", ik, 1);
      idle_bus();

      start_wr(1);
      watch(9, 5, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("abw_we_cnt", wc, 2);
      chk_i("abw_dt", df, -1);
      chk_i("abw_idle", ik, 6);
      idle_bus();

      @(negedge CLKCPU);
      AS_CPU_n = 0; DS_n = 0; RW_n = 1; FLASH_ACCESS = 1;
      watch(5, 3, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("rd_act_cnt", ac, 0);
      chk_i("rd_dt", df, -1);
      idle_bus();

      start_wr(1);
      @(negedge CLKCPU);
      @(negedge CLKCPU);
      chk("rstp_we_pre", FLASH_WE_n, 1'b0);
      RESET_n = 0;
      @(negedge CLKCPU);
      chk("rstp_we", FLASH_WE_n, 1'b1);
      chk("rstp_dt", DTACK_n, 1'b1);
      chk("rstp_act", WR_ACTIVE, 1'b0);
      RESET_n = 1;
      idle_bus();

      start_wr(1);
      watch(12, 9, 0, 0, wc, wf, df, dl, ik, ac);
      chk_i("post_we_first", wf, 1);
      chk_i("post_dt_first", df, 7);
      idle_bus();

`ifdef FLASH_WR_TIMEOUT_EN
      start_wr(1);
      watch(TMO + 10, TMO + 7, 0, TMO + 10, wc, wf, df, dl, ik, ac);
      chk_i("tmo_dt_first", df, TBW + TMO);
      chk("tmo_err", WR_ERR, 1'b1);
      idle_bus();
      start_wr(0);
      watch(4, 1, 0, 0, wc, wf, df, dl, ik, ac);
      chk("tmo_err_sticky", WR_ERR, 1'b1);
      RESET_n = 0;
      @(negedge CLKCPU);
      chk("tmo_err_rst", WR_ERR, 1'b0);
      RESET_n = 1;
      idle_bus();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
